// File: rtl/ppcm_line_buffer.sv
// ppcm_line_buffer
// Read front end between the Wishbone bus and ppcm_core. It holds one aligned
// 16-byte line (4 x 32-bit words). Read hits are acknowledged one cycle after
// the request. A read miss fetches the whole line from the core in a single
// burst. Reads to the line being filled are served as soon as their word
// arrives. Writes are acknowledged but their data is discarded.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   inv                 one-cycle pulse that invalidates the buffered line
//   wb_cyc/stb/we       bus cycle, strobe and write enable
//   wb_sel, wb_din      byte selects and write data (both ignored)
//   wb_addr             word address, byte address bits [ADDR_BITS-1:2]
//   wb_dout, wb_ack     read data and single-cycle registered acknowledge
//   core_cs/addr/burst  burst request to ppcm_core (address is line aligned)
//   core_dout/ack       one word per core_ack, in ascending order
//   core_busy           core still initialising; a miss waits for it
module ppcm_line_buffer #(
    parameter int unsigned ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inv,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [3:0]           wb_sel,
    input  logic [ADDR_BITS-3:0] wb_addr,
    input  logic [31:0]          wb_din,
    output logic [31:0]          wb_dout,
    output logic                 wb_ack,
    output logic                 core_cs,
    output logic [ADDR_BITS-3:0] core_addr,
    output logic                 core_burst,
    input  logic [31:0]          core_dout,
    input  logic                 core_busy,
    input  logic                 core_ack
);

    localparam int unsigned TAG_W = ADDR_BITS - 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [31:0]            data_q [4];
    logic [31:0]            data_d [4];
    logic                   line_valid_q, line_valid_d;
    logic [3:0]             wvalid_q, wvalid_d;
    logic [1:0]             fill_idx_q, fill_idx_d;
    logic                   inv_pend_q, inv_pend_d;
    logic                   core_cs_q, core_cs_d;
    logic                   core_burst_q, core_burst_d;
    logic [ADDR_BITS-3:0]   core_addr_q, core_addr_d;
    logic                   wb_ack_q, wb_ack_d;
    logic [31:0]            wb_dout_q, wb_dout_d;

    logic                   req, rd_req, wr_req;
    logic [TAG_W-1:0]       req_tag;
    logic [1:0]             req_idx;
    logic                   tag_match;

    // Write data and byte selects are accepted but never stored.
    logic unused_inputs;
    assign unused_inputs = ^{wb_sel, wb_din};

    assign req       = wb_cyc & wb_stb & ~wb_ack_q;
    assign rd_req    = req & ~wb_we;
    assign wr_req    = req & wb_we;
    assign req_tag   = wb_addr[ADDR_BITS-3:2];
    assign req_idx   = wb_addr[1:0];
    assign tag_match = (req_tag == tag_q);

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        data_d       = data_q;
        line_valid_d = line_valid_q;
        wvalid_d     = wvalid_q;
        fill_idx_d   = fill_idx_q;
        inv_pend_d   = inv_pend_q;
        core_cs_d    = core_cs_q;
        core_burst_d = core_burst_q;
        core_addr_d  = core_addr_q;
        wb_ack_d     = 1'b0;
        wb_dout_d    = wb_dout_q;

        if (wr_req) begin
            wb_ack_d  = 1'b1;
            wb_dout_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                // An inv arriving with a hit turns the hit into a miss.
                if (rd_req && !inv && line_valid_q && tag_match && wvalid_q[req_idx]) begin
                    wb_ack_d  = 1'b1;
                    wb_dout_d = data_q[req_idx];
                end else begin
                    if (inv) begin
                        line_valid_d = 1'b0;
                        wvalid_d     = '0;
                    end
                    // While the core is busy the miss simply retries each cycle.
                    if (rd_req && !core_busy) begin
                        tag_d        = req_tag;
                        line_valid_d = 1'b1;
                        wvalid_d     = '0;
                        core_addr_d  = {req_tag, 2'b00};
                        core_cs_d    = 1'b1;
                        core_burst_d = 1'b1;
                        fill_idx_d   = '0;
                        inv_pend_d   = 1'b0;
                        state_d      = FILL;
                    end
                end
            end

            FILL: begin
                if (inv) begin
                    inv_pend_d = 1'b1;
                end
                if (core_ack) begin
                    data_d[fill_idx_q]   = core_dout;
                    wvalid_d[fill_idx_q] = 1'b1;
                    fill_idx_d           = fill_idx_q + 2'd1;
                    if (fill_idx_q == 2'd3) begin
                        core_cs_d    = 1'b0;
                        core_burst_d = 1'b0;
                        state_d      = DRAIN;
                    end
                end
                // Early restart: the word arriving this cycle is forwarded
                // straight from core_dout so the ack lands one cycle later.
                if (rd_req && tag_match) begin
                    if (wvalid_q[req_idx]) begin
                        wb_ack_d  = 1'b1;
                        wb_dout_d = data_q[req_idx];
                    end else if (core_ack && (fill_idx_q == req_idx)) begin
                        wb_ack_d  = 1'b1;
                        wb_dout_d = core_dout;
                    end
                end
            end

            DRAIN: begin
                // An inv seen during the fill takes effect here, as IDLE is entered.
                if (inv_pend_q || inv) begin
                    line_valid_d = 1'b0;
                    wvalid_d     = '0;
                end
                inv_pend_d = 1'b0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            line_valid_q <= 1'b0;
            wvalid_q     <= '0;
            fill_idx_q   <= '0;
            inv_pend_q   <= 1'b0;
            core_cs_q    <= 1'b0;
            core_burst_q <= 1'b0;
            core_addr_q  <= '0;
            wb_ack_q     <= 1'b0;
            wb_dout_q    <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            line_valid_q <= line_valid_d;
            wvalid_q     <= wvalid_d;
            fill_idx_q   <= fill_idx_d;
            inv_pend_q   <= inv_pend_d;
            core_cs_q    <= core_cs_d;
            core_burst_q <= core_burst_d;
            core_addr_q  <= core_addr_d;
            wb_ack_q     <= wb_ack_d;
            wb_dout_q    <= wb_dout_d;
        end
    end

    assign wb_ack     = wb_ack_q;
    assign wb_dout    = wb_dout_q;
    assign core_cs    = core_cs_q;
    assign core_burst = core_burst_q;
    assign core_addr  = core_addr_q;

endmodule

// File: doc/ppcm_line_buffer.md
Name: ppcm_line_buffer

Overview:
Wishbone-side read front end for the parallel PCM core.
- Serves 32-bit reads from a one-line (4-word, 16-byte) buffer.
- On a miss, fetches the whole aligned line from ppcm_core with one burst.
- Sits between the system bus and ppcm_core; drives ppcm_core's cs/addr/burst and consumes its dout/ack.

Parameters:
ADDR_BITS, 24, byte address width of PCM space; must match ppcm_core.

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active high
inv  in  1  single-cycle pulse that invalidates the line buffer
wb_cyc  in  1  bus cycle
wb_stb  in  1  bus strobe
wb_we  in  1  write enable; writes are not supported
wb_sel  in  4  byte selects; ignored
wb_addr  in  ADDR_BITS-2  word address, [ADDR_BITS-1:2]
wb_din  in  32  write data; ignored
wb_dout  out  32  read data
wb_ack  out  1  acknowledge
core_cs  out  1  to ppcm_core cs
core_addr  out  ADDR_BITS-2  to ppcm_core addr, always line-aligned ([3:2]=0)
core_burst  out  1  to ppcm_core burst
core_dout  in  32  from ppcm_core dout
core_busy  in  1  from ppcm_core busy
core_ack  in  1  from ppcm_core ack; one word per pulse, ascending order

Behaviour:
- Reset values: wb_ack=0, wb_dout=0, core_cs=0, core_burst=0, core_addr=0, line valid=0, all word-valid bits=0, state=IDLE.
- Storage:
  - tag = wb_addr[ADDR_BITS-1:4]
  - data[0..3] (32-bit)
  - line_valid
  - wvalid[3:0]
- A request is wb_cyc & wb_stb & ~wb_ack.
- wb_ack is a single-cycle registered pulse, never asserted for two consecutive cycles.
- Writes (wb_we=1): ack on the next cycle, data discarded, buffer unchanged, wb_dout=0.
- Read hit: requires line_valid, tag match, and wvalid[wb_addr[3:2]].
  - wb_ack and wb_dout=data[idx] are registered on the next edge (1-cycle latency).
- States:
  - IDLE: read miss (tag mismatch or !line_valid) with core_busy=0 -> FILL. On entry:
    - tag <= request tag; line_valid <= 1; wvalid <= 0
    - core_addr <= {tag,2'b00}; core_cs <= 1; core_burst <= 1; fill index <= 0
    - Miss while core_busy=1 (PCM initialising): stay IDLE and retry each cycle.
  - FILL:
    - Each core_ack: data[idx] <= core_dout; wvalid[idx] <= 1; idx++.
    - On the 4th core_ack: core_cs <= 0, core_burst <= 0 registered, -> DRAIN.
    - core_cs and core_addr are held stable throughout FILL.
    - Early restart: a pending read to the filling line acks the cycle after its word is written (data forwarded from core_dout on the ack cycle is allowed). Reads to other lines stall until DRAIN ends.
  - DRAIN: one cycle so the core returns to idle with cs low -> IDLE.
- The core ends a burst at the 16-byte boundary, so exactly 4 core_acks occur per fill. core_cs must be low by the second cycle after the 4th core_ack.
- inv:
  - In IDLE: line_valid <= 0 and wvalid <= 0.
  - In FILL: recorded, applied on entry to IDLE. The in-flight fill completes, but its line is not valid afterwards; pending early-restart requests are still served.
- Simultaneous hit request and inv in IDLE: the request is treated as a miss.
- Bus master drops wb_cyc mid-fill: the fill completes and the buffer stays valid; no wb_ack is issued for the abandoned request.
- rst mid-fill: everything returns to reset values on the next edge; core_cs=0 immediately; any later core_ack is ignored in IDLE.

Test Plan:
- Post-reset, core_busy=1 for 50 cycles, read 0x000010 -> core_cs stays 0 until busy falls, then core_addr=0x000004 (word), burst=1; after 4 core_acks (0xA0..0xA3) wb_dout=0xA0, wb_ack once.
- Read word addr 0x5 immediately after the previous fill -> hit, wb_ack 1 cycle after stb, wb_dout=0xA1, core_cs remains 0.
- Miss to word addr 0x13 -> fill of line 0x10..0x13; wb_ack only after the 4th core_ack, wb_dout = 4th word; core_cs low within 2 cycles.
- Write to 0x5 -> ack in 1 cycle, no core activity, subsequent read 0x5 still returns 0xA1.
- Pulse inv during a fill, then read the same line -> new fill issued (core_cs rises again).
- Assert rst after the 2nd core_ack -> core_cs=0, wb_ack=0 next cycle; read of the same line afterwards triggers a full refetch.
